dense_classifier: RTL

Fully connected output stage of the CNN, downstream of the second-layer maxpooling bank. It snapshots the pooled feature maps (N_CH × SIZE_IN × SIZE_IN), flattens them, and computes N_OUT neurons with a single time-multiplexed MAC. Weights come from a synchronous external ROM. It emits saturated Q-format scores and the argmax class index with a one-cycle done pulse.

---
 rtl/cnn_pkg.sv | 14 +
 rtl/dense_mac.sv | 29 ++
 rtl/dense_classifier.sv | 98 +++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared data widths, dense FSM states and the accumulator saturation helper
package cnn_pkg;
  localparam int WIDTH_BIT = 16;
  localparam int FRAC_BITS = 8;
  localparam int ACC_WIDTH = 40;
  typedef enum logic [2:0] {IDLE, MAC, DRAIN, ARGMAX, DONE} dense_state_t;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (WIDTH_BIT-1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
  function automatic logic signed [WIDTH_BIT-1:0] sat_trunc(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] s;
    s = a >>> FRAC_BITS;
    return s > SAT_MAX ? WIDTH_BIT'(SAT_MAX) : s < SAT_MIN ? WIDTH_BIT'(SAT_MIN) : WIDTH_BIT'(s);
  endfunction
endpackage

// File: rtl/dense_mac.sv
// dense_mac: signed MAC with bias add, Q-format shift and saturation.
// DENSE_RELU_EN clamps negative scores to zero after saturation.
module dense_mac
  import cnn_pkg::*;
(
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        acc_en,
  input  logic                        clr,
  input  logic signed [WIDTH_BIT-1:0] feature,
  input  logic signed [WIDTH_BIT-1:0] weight,
  output logic signed [WIDTH_BIT-1:0] result
);
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [2*WIDTH_BIT-1:0] prod;
  logic signed [WIDTH_BIT-1:0] sat;
  assign prod = (2*WIDTH_BIT)'(feature) * (2*WIDTH_BIT)'(weight);
  // weight carries the bias during drain; align it to the product's fraction
  assign sat = sat_trunc(acc + (ACC_WIDTH'(weight) <<< FRAC_BITS));
`ifdef DENSE_RELU_EN
  assign result = sat[WIDTH_BIT-1] ? '0 : sat;
`else
  assign result = sat;
`endif
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) acc <= '0;
    else if (clr) acc <= '0;
    else if (acc_en) acc <= acc + ACC_WIDTH'(prod);
endmodule

// File: rtl/dense_classifier.sv
// dense_classifier: snapshot + flatten pooled maps, time-multiplexed FC neurons, argmax.
// Optional DENSE_RELU_EN applies ReLU to stored scores.
module dense_classifier
  import cnn_pkg::*;
#(
  parameter int N_CH = 16,
  parameter int SIZE_IN = 4,
  parameter int N_OUT = 10,
  localparam int N_IN = N_CH*SIZE_IN*SIZE_IN,
  localparam int ADDR_W = $clog2(N_OUT*(N_IN+1)),
  localparam int CLS_W = $clog2(N_OUT)
)(
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        start,
  input  logic signed [WIDTH_BIT-1:0] featureIn [N_CH][SIZE_IN][SIZE_IN],
  output logic [ADDR_W-1:0]           weightAddr,
  input  logic signed [WIDTH_BIT-1:0] weightData,
  output logic                        busy,
  output logic                        done,
  output logic signed [WIDTH_BIT-1:0] denseOut [N_OUT],
  output logic [CLS_W-1:0]            classOut
);
  localparam int IDX_W = $clog2(N_IN+2);
  localparam int FI_W = $clog2(N_IN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN);
  localparam logic [IDX_W-1:0] ARG_END = IDX_W'(N_OUT);
  localparam logic [CLS_W-1:0] LAST_NRN = CLS_W'(N_OUT-1);
  dense_state_t state;
  logic [IDX_W-1:0] idx;
  logic [CLS_W-1:0] neuron, best_idx, aidx;
  logic [FI_W-1:0] fidx;
  logic signed [WIDTH_BIT-1:0] best_val, result, cand;
  logic signed [WIDTH_BIT-1:0] feat [N_IN];
  // ROM data lags the address by one cycle, so pair it with the previous feature
  assign fidx = FI_W'(idx - IDX_W'(1));
  assign aidx = CLS_W'(idx);
  assign cand = denseOut[aidx];
  assign busy = state inside {MAC, DRAIN, ARGMAX};
  assign done = state == DONE;
  dense_mac u_mac (
    .clock(clock),
    .nreset(nreset),
    .acc_en(state == MAC && idx != '0),
    .clr(state != MAC),
    .feature(feat[fidx]),
    .weight(weightData),
    .result(result)
  );
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      state <= IDLE;
      idx <= '0;
      neuron <= '0;
      weightAddr <= '0;
      classOut <= '0;
      best_idx <= '0;
      best_val <= '0;
      for (int i = 0; i < N_OUT; i++) denseOut[i] <= '0;
      for (int i = 0; i < N_IN; i++) feat[i] <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= MAC;
          idx <= '0;
          neuron <= '0;
          weightAddr <= '0;
          for (int c = 0; c < N_CH; c++)
            for (int r = 0; r < SIZE_IN; r++)
              for (int k = 0; k < SIZE_IN; k++)
                feat[(c*SIZE_IN+r)*SIZE_IN+k] <= featureIn[c][r][k];
        end
        MAC: begin
          idx <= idx + IDX_W'(1);
          weightAddr <= weightAddr + ADDR_W'(1);
          if (idx == LAST_IDX) state <= DRAIN;
        end
        DRAIN: begin
          denseOut[neuron] <= result;
          idx <= '0;
          neuron <= neuron + CLS_W'(1);
          state <= neuron == LAST_NRN ? ARGMAX : MAC;
        end
        // strict greater keeps the lowest index on ties
        ARGMAX: begin
          idx <= idx + IDX_W'(1);
          if (idx == ARG_END) begin
            classOut <= best_idx;
            state <= DONE;
          end else if (idx == '0 || cand > best_val) begin
            best_val <= cand;
            best_idx <= aidx;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule
